// File: rtl/toast_sequencer.sv
// Toaster cycle controller: latches time/duty on start, then sequences the
// timer_pwm block through PREHEAT -> TOAST -> WARM -> DONE with load handshakes.
module toast_sequencer #(
  parameter int unsigned PREHEAT_S   = 10,
  parameter int unsigned PREHEAT_DC  = 100,
  parameter int unsigned WARM_S      = 30,
  parameter int unsigned WARM_DC     = 20,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned BEEP_CYCLES = 4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        stop_btn,
  input  logic        lever_down,
  input  logic [9:0]  set_time,
  input  logic [7:0]  set_dc,
  input  logic        write_ack,
  input  logic [11:0] tled,
  output logic        tmr_write,
  output logic [9:0]  tmr_time,
  output logic [7:0]  tmr_dc,
  output logic        tmr_start,
  output logic        beep,
  output logic        busy,
  output logic        error,
  output logic [2:0]  state_o
);

  localparam int unsigned ACK_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned BEEP_W = $clog2(BEEP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    PREHEAT = 3'd2,
    TOAST   = 3'd3,
    WARM    = 3'd4,
    DONE    = 3'd5,
    CLEAR   = 3'd6
  } state_t;

  state_t              state, state_nx, tgt, tgt_nx;
  logic [9:0]          toast_time, toast_time_nx;
  logic [7:0]          toast_dc, toast_dc_nx;
  logic                start_prev, entered, error_nx;
  logic [ACK_W-1:0]    ack_cnt;
  logic [BEEP_W-1:0]   beep_cnt;
  logic                write_nx, start_nx;
  logic [9:0]          time_nx;
  logic [7:0]          dc_nx;
  logic                abort_c, ack_ok_c, ack_to_c, phase_done_c, accept_c, beep_end_c;

  // Next phase after a completed one; zero-length phases are skipped.
  function automatic state_t after_phase(input state_t s);
    after_phase = DONE;
    if (s == PREHEAT)                 after_phase = TOAST;
    else if (s == TOAST && WARM_S != 0) after_phase = WARM;
  endfunction

  function automatic logic [9:0] phase_time(input state_t s, input logic [9:0] tt);
    phase_time = 10'd0;
    case (s)
      PREHEAT: phase_time = 10'(PREHEAT_S);
      TOAST:   phase_time = tt;
      WARM:    phase_time = 10'(WARM_S);
      default: phase_time = 10'd0;
    endcase
  endfunction

  function automatic logic [7:0] phase_dc(input state_t s, input logic [7:0] td);
    phase_dc = 8'd0;
    case (s)
      PREHEAT: phase_dc = 8'(PREHEAT_DC);
      TOAST:   phase_dc = td;
      WARM:    phase_dc = 8'(WARM_DC);
      default: phase_dc = 8'd0;
    endcase
  endfunction

  assign abort_c      = stop_btn || !lever_down;
  assign ack_ok_c     = tmr_write && write_ack;
  assign ack_to_c     = tmr_write && !write_ack && (ack_cnt == ACK_W'(ACK_TIMEOUT - 1));
  // The entry cycle may still show the previous timer content, so ignore it.
  assign phase_done_c = !entered && (tled == 12'd0);
  assign accept_c     = start_btn && !start_prev && lever_down && !stop_btn &&
                        (set_time != 10'd0);
  assign beep_end_c   = (beep_cnt == BEEP_W'(BEEP_CYCLES - 1));
  assign state_o      = state;

  // State and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CLEAR;
      tgt        <= TOAST;
      toast_time <= 10'd0;
      toast_dc   <= 8'd0;
      start_prev <= 1'b0;
      entered    <= 1'b1;
      ack_cnt    <= '0;
      beep_cnt   <= '0;
      tmr_write  <= 1'b0;
      tmr_time   <= 10'd0;
      tmr_dc     <= 8'd0;
      tmr_start  <= 1'b0;
      beep       <= 1'b0;
      busy       <= 1'b1;
      error      <= 1'b0;
    end else begin
      state      <= state_nx;
      tgt        <= tgt_nx;
      toast_time <= toast_time_nx;
      toast_dc   <= toast_dc_nx;
      start_prev <= start_btn;
      entered    <= (state_nx != state);
      tmr_write  <= write_nx;
      tmr_time   <= time_nx;
      tmr_dc     <= dc_nx;
      tmr_start  <= start_nx;
      beep       <= (state_nx == DONE);
      busy       <= (state_nx != IDLE);
      error      <= error_nx;
      if (state_nx != state)
        ack_cnt <= '0;
      else if (tmr_write && ack_cnt < ACK_W'(ACK_TIMEOUT))
        ack_cnt <= ack_cnt + ACK_W'(1);
      if (state_nx != state)
        beep_cnt <= '0;
      else if (state == DONE && beep_cnt < BEEP_W'(BEEP_CYCLES))
        beep_cnt <= beep_cnt + BEEP_W'(1);
    end
  end

  // Next state, latched settings and next output values.
  always_comb begin
    state_nx      = state;
    tgt_nx        = tgt;
    toast_time_nx = toast_time;
    toast_dc_nx   = toast_dc;
    error_nx      = error;
    write_nx      = 1'b0;
    time_nx       = 10'd0;
    dc_nx         = 8'd0;
    start_nx      = 1'b0;

    case (state)
      IDLE: begin
        if (accept_c) begin
          state_nx      = LOAD;
          tgt_nx        = (PREHEAT_S != 0) ? PREHEAT : TOAST;
          toast_time_nx = set_time;
          toast_dc_nx   = (set_dc > 8'd100) ? 8'd100 : set_dc;
          error_nx      = 1'b0;
        end
      end
      LOAD: begin
        if (abort_c) begin
          state_nx = CLEAR;
        end else if (ack_to_c) begin
          state_nx = CLEAR;
          error_nx = 1'b1;
        end else if (ack_ok_c) begin
          state_nx = tgt;
        end
      end
      PREHEAT, TOAST, WARM: begin
        if (abort_c) begin
          state_nx = CLEAR;
        end else if (phase_done_c) begin
          if (after_phase(state) == DONE) begin
            state_nx = DONE;
          end else begin
            state_nx = LOAD;
            tgt_nx   = after_phase(state);
          end
        end
      end
      DONE: begin
        if (abort_c || beep_end_c) state_nx = IDLE;
      end
      CLEAR: begin
        if (ack_to_c) begin
          state_nx = IDLE;
          error_nx = 1'b1;
        end else if (ack_ok_c) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = CLEAR;
    endcase

    write_nx = (state_nx == LOAD) || (state_nx == CLEAR);
    if (state_nx == LOAD) time_nx = phase_time(tgt_nx, toast_time_nx);
    start_nx = (state_nx == PREHEAT) || (state_nx == TOAST) || (state_nx == WARM);
    if (start_nx) dc_nx = phase_dc(state_nx, toast_dc_nx);
  end

endmodule

// File: tb/tb_toast_sequencer.sv
// Directed bench for toast_sequencer: start-acceptance vector table plus
// hand-written full-cycle, abort, timeout, reset and skipped-phase sequences.
module tb_toast_sequencer;

  logic        clk = 1'b0;
  logic        reset, start_btn, stop_btn, lever, lever5, ack_en, which;
  logic [9:0]  set_time;
  logic [7:0]  set_dc;

  logic        wr_a, st_a, bp_a, bz_a, er_a, ack_a;
  logic [9:0]  tm_a;
  logic [7:0]  dc_a;
  logic [2:0]  so_a;
  logic [11:0] tled_a;
  logic        wr_b, st_b, bp_b, bz_b, er_b, ack_b;
  logic [9:0]  tm_b;
  logic [7:0]  dc_b;
  logic [2:0]  so_b;
  logic [11:0] tled_b;

  logic [9:0]  tcnt_a = 10'd7;
  logic [9:0]  tcnt_b = 10'd7;

  logic [2:0]  o_state;
  logic        o_write, o_start, o_beep, o_busy, o_error;
  logic [9:0]  o_time;
  logic [7:0]  o_dc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  toast_sequencer dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .stop_btn(stop_btn),
    .lever_down(lever), .set_time(set_time), .set_dc(set_dc),
    .write_ack(ack_a), .tled(tled_a), .tmr_write(wr_a), .tmr_time(tm_a),
    .tmr_dc(dc_a), .tmr_start(st_a), .beep(bp_a), .busy(bz_a), .error(er_a),
    .state_o(so_a)
  );

  toast_sequencer #(.PREHEAT_S(0), .WARM_S(0)) dut5 (
    .clk(clk), .reset(reset), .start_btn(start_btn), .stop_btn(stop_btn),
    .lever_down(lever5), .set_time(set_time), .set_dc(set_dc),
    .write_ack(ack_b), .tled(tled_b), .tmr_write(wr_b), .tmr_time(tm_b),
    .tmr_dc(dc_b), .tmr_start(st_b), .beep(bp_b), .busy(bz_b), .error(er_b),
    .state_o(so_b)
  );

  // Simple timer models: immediate ack, one count per clock while running.
  assign ack_a  = wr_a & ack_en;
  assign ack_b  = wr_b & ack_en;
  assign tled_a = {2'b00, tcnt_a};
  assign tled_b = {2'b00, tcnt_b};

  always @(posedge clk) begin
    if (wr_a && ack_a)              tcnt_a <= tm_a;
    else if (st_a && tcnt_a != 0)   tcnt_a <= tcnt_a - 10'd1;
    if (wr_b && ack_b)              tcnt_b <= tm_b;
    else if (st_b && tcnt_b != 0)   tcnt_b <= tcnt_b - 10'd1;
  end

  always_comb begin
    o_state = which ? so_b : so_a;
    o_write = which ? wr_b : wr_a;
    o_start = which ? st_b : st_a;
    o_beep  = which ? bp_b : bp_a;
    o_busy  = which ? bz_b : bz_a;
    o_error = which ? er_b : er_a;
    o_time  = which ? tm_b : tm_a;
    o_dc    = which ? dc_b : dc_a;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic wait_st(input logic [2:0] code, input int budget, input string nm);
    int n = 0;
    while (o_state !== code && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(o_state), 32'(code));
  endtask

  task automatic do_start(input logic [9:0] t, input logic [7:0] d);
    set_time  = t;
    set_dc    = d;
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
  endtask

  typedef struct {
    logic       start;
    logic       stop;
    logic       lv;
    logic [9:0] tm;
    logic [2:0] exp_st;
    logic       exp_wr;
    logic [9:0] exp_time;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{1'b1, 1'b0, 1'b1, 10'd0,   3'd0, 1'b0, 10'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 10'd45,  3'd0, 1'b0, 10'd0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 10'd45,  3'd0, 1'b0, 10'd0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 10'd45,  3'd0, 1'b0, 10'd0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 10'd1,   3'd1, 1'b1, 10'd10};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 10'd999, 3'd1, 1'b1, 10'd10};

    reset = 1'b1; start_btn = 1'b0; stop_btn = 1'b0; lever = 1'b0; lever5 = 1'b0;
    set_time = 10'd0; set_dc = 8'd0; ack_en = 1'b1; which = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_state", 32'(o_state), 6);
    chk("rst_busy",  32'(o_busy), 1);
    chk("rst_write", 32'(o_write), 0);
    chk("rst_start", 32'(o_start), 0);
    chk("rst_dc",    32'(o_dc), 0);
    chk("rst_beep",  32'(o_beep), 0);
    chk("rst_error", 32'(o_error), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("clr_write", 32'(o_write), 1);
    chk("clr_time",  32'(o_time), 0);
    wait_st(3'd0, 10, "clr_to_idle");
    chk("clr_timer_zero", 32'(tcnt_a), 0);

    // Start acceptance table
    for (int i = 0; i < 6; i++) begin
      start_btn = 1'b0; stop_btn = 1'b0;
      @(negedge clk);
      start_btn = vecs[i].start; stop_btn = vecs[i].stop;
      lever = vecs[i].lv; set_time = vecs[i].tm; set_dc = 8'd50;
      @(negedge clk);
      chk($sformatf("vec%0d_state", i), 32'(o_state), 32'(vecs[i].exp_st));
      chk($sformatf("vec%0d_write", i), 32'(o_write), 32'(vecs[i].exp_wr));
      chk($sformatf("vec%0d_time", i),  32'(o_time),  32'(vecs[i].exp_time));
      start_btn = 1'b0; stop_btn = 1'b0;
      if (vecs[i].exp_st == 3'd1) begin
        stop_btn = 1'b1;
        @(negedge clk);
        stop_btn = 1'b0;
        wait_st(3'd0, 10, $sformatf("vec%0d_back_idle", i));
      end else begin
        n = 0;
        repeat (4) begin
          @(negedge clk);
          if (o_write) n++;
        end
        chk($sformatf("vec%0d_no_write", i), 32'(n), 0);
      end
    end

    // T1: full cycle; start held throughout, settings edited mid-cycle
    lever = 1'b1; set_time = 10'd45; set_dc = 8'd60; start_btn = 1'b1;
    @(negedge clk);
    chk("t1_load_pre_state", 32'(o_state), 1);
    chk("t1_load_pre_time",  32'(o_time), 10);
    chk("t1_load_pre_start", 32'(o_start), 0);
    set_time = 10'd99; set_dc = 8'd7;
    @(negedge clk);
    chk("t1_pre_state", 32'(o_state), 2);
    chk("t1_pre_dc",    32'(o_dc), 100);
    chk("t1_pre_start", 32'(o_start), 1);
    chk("t1_pre_write", 32'(o_write), 0);
    wait_st(3'd1, 20, "t1_load_toast");
    chk("t1_load_toast_time", 32'(o_time), 45);
    chk("t1_load_toast_dc",   32'(o_dc), 0);
    @(negedge clk);
    chk("t1_toast_state", 32'(o_state), 3);
    chk("t1_toast_dc",    32'(o_dc), 60);
    n = 0;
    while (o_state == 3'd3 && n < 200) begin n++; @(negedge clk); end
    chk("t1_toast_len", 32'(n), 46);
    chk("t1_load_warm_state", 32'(o_state), 1);
    chk("t1_load_warm_time",  32'(o_time), 30);
    @(negedge clk);
    chk("t1_warm_state", 32'(o_state), 4);
    chk("t1_warm_dc",    32'(o_dc), 20);
    wait_st(3'd5, 40, "t1_done");
    n = 0;
    while (o_beep && n < 5000) begin n++; @(negedge clk); end
    chk("t1_beep_len",   32'(n), 4000);
    chk("t1_idle_state", 32'(o_state), 0);
    chk("t1_idle_busy",  32'(o_busy), 0);
    repeat (5) @(negedge clk);
    chk("t1_no_autorestart", 32'(o_state), 0);
    start_btn = 1'b0;
    @(negedge clk);

    // T2: stop in TOAST
    do_start(10'd30, 8'd50);
    wait_st(3'd3, 30, "t2_toast");
    repeat (5) @(negedge clk);
    stop_btn = 1'b1;
    @(negedge clk);
    stop_btn = 1'b0;
    chk("t2_state", 32'(o_state), 6);
    chk("t2_start", 32'(o_start), 0);
    chk("t2_dc",    32'(o_dc), 0);
    chk("t2_write", 32'(o_write), 1);
    chk("t2_time",  32'(o_time), 0);
    wait_st(3'd0, 10, "t2_idle");
    chk("t2_timer_zero", 32'(tcnt_a), 0);

    // T3: ack timeout in first LOAD, error cleared by next start
    ack_en = 1'b0;
    do_start(10'd20, 8'd50);
    n = 0;
    while (o_state == 3'd1 && n < 100) begin n++; @(negedge clk); end
    chk("t3_load_cycles", 32'(n), 16);
    chk("t3_state", 32'(o_state), 6);
    chk("t3_error", 32'(o_error), 1);
    ack_en = 1'b1;
    wait_st(3'd0, 10, "t3_idle");
    chk("t3_error_sticky", 32'(o_error), 1);
    do_start(10'd20, 8'd50);
    chk("t3_restart_state", 32'(o_state), 1);
    chk("t3_error_cleared", 32'(o_error), 0);
    lever = 1'b0;
    @(negedge clk);
    lever = 1'b1;
    chk("t3_lever_abort", 32'(o_state), 6);
    wait_st(3'd0, 10, "t3_idle2");

    // T6: reset during WARM
    do_start(10'd5, 8'd50);
    wait_st(3'd4, 60, "t6_warm");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_state", 32'(o_state), 6);
    chk("t6_write", 32'(o_write), 0);
    chk("t6_start", 32'(o_start), 0);
    chk("t6_dc",    32'(o_dc), 0);
    chk("t6_busy",  32'(o_busy), 1);
    chk("t6_time",  32'(o_time), 0);
    @(negedge clk);
    reset = 1'b0;
    wait_st(3'd0, 20, "t6_idle");
    chk("t6_timer_zero", 32'(tcnt_a), 0);

    // T5: no preheat/warm, duty clamp
    lever = 1'b0; lever5 = 1'b1; which = 1'b1;
    do_start(10'd20, 8'd150);
    chk("t5_load_state", 32'(o_state), 1);
    chk("t5_load_time",  32'(o_time), 20);
    @(negedge clk);
    chk("t5_toast_state", 32'(o_state), 3);
    chk("t5_toast_dc",    32'(o_dc), 100);
    n = 0;
    while (o_state == 3'd3 && n < 100) begin n++; @(negedge clk); end
    chk("t5_toast_len",   32'(n), 21);
    chk("t5_direct_done", 32'(o_state), 5);
    wait_st(3'd0, 4100, "t5_idle");
    lever5 = 1'b0; which = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
